// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage and its lane logic.
//   SZ_*        : access size encodings carried on size2
//   state_e     : access FSM states
//   CNT_W       : width of the dmem_ack wait counter
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int unsigned CNT_W = 8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic for a 32-bit data memory port.
//   addr_lo     in  2   low address bits (byte lane)
//   size        in  2   00 byte, 01 half, 10/11 word
//   unsigned_ld in  1   zero-extend sub-word loads
//   rdata       in  32  raw memory word
//   wdata_in    in  32  store data, right-aligned
//   load_data   out 32  extracted and extended load value
//   store_data  out 32  lane-replicated store word
//   store_be    out 4   byte enables for a store
//   misaligned  out 1   half on odd address or word not on a 4-byte boundary
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata_in,
  output logic [31:0] load_data,
  output logic [31:0] store_data,
  output logic [3:0]  store_be,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    load_data  = rdata;
    store_data = wdata_in;
    store_be   = 4'b1111;
    misaligned = 1'b0;

    case (size)
      SZ_BYTE: begin
        load_data  = {{24{~unsigned_ld & byte_sel[7]}}, byte_sel};
        store_data = {4{wdata_in[7:0]}};
        store_be   = 4'b0001 << addr_lo;
      end
      SZ_HALF: begin
        load_data  = {{16{~unsigned_ld & half_sel[15]}}, half_sel};
        store_data = {2{wdata_in[15:0]}};
        store_be   = addr_lo[1] ? 4'b1100 : 4'b0011;
        misaligned = addr_lo[0];
      end
      default: begin
        // SZ_WORD and the reserved encoding both behave as a word access
        misaligned = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage between EX/MEM and MEM_WB with a req/ack data port.
//   clk, reset            : clock, synchronous active-high reset
//   aluresult1/writedata1 : address/ALU result and store data from EX/MEM
//   desreg1, Memread2, Memwrite2, Memtoreg2, Regwrite2, size2, unsigned2
//                         : control from EX/MEM
//   dmem_*                : data memory request/response port
//   stall                 : freezes PC, IF/ID, ID/EX and EX/MEM
//   mem_err               : sticky misalignment/timeout flag
//   readdate1, aluresult2, desreg2, Memtoreg3, Regwrite3 : to MEM_WB
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] aluresult1,
  input  logic [31:0] writedata1,
  input  logic [4:0]  desreg1,
  input  logic        Memread2,
  input  logic        Memwrite2,
  input  logic        Memtoreg2,
  input  logic        Regwrite2,
  input  logic [1:0]  size2,
  input  logic        unsigned2,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        mem_err,
  output logic [31:0] readdate1,
  output logic [31:0] aluresult2,
  output logic [4:0]  desreg2,
  output logic        Memtoreg3,
  output logic        Regwrite3
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             req_q, req_d;

  logic        acc;
  logic        bubble;
  logic        squash;
  logic [31:0] load_data;
  logic [31:0] store_data;
  logic [3:0]  store_be;
  logic        misaligned;

  assign acc = Memread2 | Memwrite2;

  mem_lane_align u_lane (
    .addr_lo     (aluresult1[1:0]),
    .size        (size2),
    .unsigned_ld (unsigned2),
    .rdata       (rdata_q),
    .wdata_in    (writedata1),
    .load_data   (load_data),
    .store_data  (store_data),
    .store_be    (store_be),
    .misaligned  (misaligned)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    done_d  = done_q;
    err_d   = err_q;
    req_d   = req_q;
    stall   = 1'b0;
    bubble  = 1'b0;
    squash  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!acc || done_q) begin
          // done marks the single cycle a completed access is handed on
          done_d = 1'b0;
        end else if (misaligned) begin
          err_d  = 1'b1;
          squash = 1'b1;
        end else begin
          stall   = 1'b1;
          bubble  = 1'b1;
          state_d = S_BUSY;
          req_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      S_BUSY: begin
        stall  = 1'b1;
        bubble = 1'b1;
        if (dmem_ack) begin
          rdata_d = dmem_rdata;
          done_d  = 1'b1;
          req_d   = 1'b0;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          // abandoned access completes with zero data and the error flag
          rdata_d = '0;
          err_d   = 1'b1;
          done_d  = 1'b1;
          req_d   = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (reset) begin
      stall  = 1'b0;
      bubble = 1'b0;
      squash = 1'b1;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = Memwrite2 & ~Memread2;
  assign dmem_addr  = {aluresult1[31:2], 2'b00};
  assign dmem_wdata = store_data;
  assign dmem_be    = Memread2 ? 4'b1111 : store_be;
  assign mem_err    = err_q;

  assign readdate1  = Memread2 ? load_data : '0;
  assign aluresult2 = aluresult1;
  assign desreg2    = bubble ? '0 : desreg1;
  assign Regwrite3  = Regwrite2 & ~(bubble | squash);
  assign Memtoreg3  = Memtoreg2 & ~(bubble | squash);

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM pipeline stage: sits between the EX/MEM register and MEM_WB, and produces exactly the inputs MEM_WB captures (readdate1, aluresult2, desreg2, Memtoreg3, Regwrite3).
- Drives a req/ack data-memory port and performs byte/halfword/word load extraction and store lane steering.
- Stalls the front of the pipeline while an access is outstanding. Because MEM_WB loads every clock, bubbles are inserted downstream during stalls.

Parameters:
- TIMEOUT, 16, maximum cycles waiting for dmem_ack before the access is abandoned (range 1..255)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- aluresult1  in  32  effective address or ALU result from EX/MEM
- writedata1  in  32  store data (rt) from EX/MEM
- desreg1  in  5  destination register
- Memread2  in  1  load
- Memwrite2  in  1  store
- Memtoreg2  in  1  writeback selects memory data
- Regwrite2  in  1  register write enable
- size2  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word)
- unsigned2  in  1  zero-extend loads (lbu/lhu)
- dmem_req  out  1  memory request, held until ack
- dmem_we  out  1  write request
- dmem_addr  out  32  word-aligned address ({aluresult1[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ack  in  1  one-cycle completion strobe
- dmem_rdata  in  32  read word; valid when dmem_ack=1
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- mem_err  out  1  sticky error: misaligned access or timeout
- readdate1  out  32  extracted load data to MEM_WB
- aluresult2  out  32  pass-through of aluresult1
- desreg2  out  5  destination to MEM_WB
- Memtoreg3  out  1  to MEM_WB
- Regwrite3  out  1  to MEM_WB

Behaviour:
- Define acc = Memread2 | Memwrite2.
- Misalignment: half with addr[0]=1, or word with addr[1:0]≠0.
- Two-state FSM, IDLE and BUSY. An 8-bit wait counter, a 32-bit rdata_q and a done flag are registered.
- Reset values: state=IDLE, counter=0, rdata_q=0, done=0, mem_err=0, dmem_req=0.
  - Outputs while reset is asserted: stall=0, Regwrite3=0, Memtoreg3=0.
- IDLE with acc=0, or acc=1 with done=1:
  - stall=0.
  - Pass-through to MEM_WB: desreg2=desreg1, Regwrite3=Regwrite2, Memtoreg3=Memtoreg2.
  - done clears at the end of this cycle.
- IDLE with acc=1, done=0, misaligned:
  - No memory request; stall=0; mem_err sets.
  - Regwrite3=0 and Memtoreg3=0, so the instruction is squashed.
- IDLE with acc=1, done=0, aligned:
  - stall=1 combinationally in this cycle.
  - Bubble to MEM_WB: Regwrite3=0, Memtoreg3=0, desreg2=0.
  - Next state BUSY; dmem_req=1 registered; counter=0.
- BUSY:
  - stall=1 and bubble outputs.
  - dmem_req held at 1; addr, we, be and wdata are held stable because EX/MEM is frozen.
- BUSY with dmem_ack=1:
  - rdata_q<=dmem_rdata; done<=1; dmem_req<=0; next state IDLE.
  - On the following IDLE cycle the instruction passes with stall=0, so MEM_WB captures it exactly once.
- BUSY with no ack and counter=TIMEOUT-1:
  - Treated as completion: rdata_q<=0, mem_err sets, dmem_req<=0, done<=1.
  - A late ack arriving in IDLE is ignored.
- Load latency: minimum 3 cycles from the instruction entering MEM to valid output (issue, ack, pass). A zero-wait ack therefore costs 2 stall cycles.
- Load extraction from rdata_q:
  - byte lane = addr[1:0]; half lane = addr[1].
  - Sign-extend unless unsigned2=1.
  - For non-loads, readdate1=0.
- Store steering:
  - byte: wdata={4{wd[7:0]}}, be=1<<addr[1:0].
  - half: wdata={2{wd[15:0]}}, be=addr[1]?1100:0011.
  - word: be=1111.
  - For loads, be=1111 and dmem_we=0.
- Pass-through: aluresult2=aluresult1 at all times.
- Reset mid-access: FSM returns to IDLE and dmem_req drops the next cycle. A memory subsystem may still complete the access; its ack is ignored.

Decomposition:
- Shared package mem_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - FSM state enum S_IDLE, S_BUSY;
  - the width constant for the 8-bit wait counter.
- The natural sub-module is the combinational lane logic, named mem_lane_align. It covers load extraction/extension, store replication, the byte-enable mask and the misalignment check, and is reused by any future I-cache/D-cache.

Test Plan:
- lw at address 0x100, ack on the first BUSY cycle with rdata=0xDEADBEEF -> stall high 2 cycles, then readdate1=0xDEADBEEF with Regwrite3=1 for exactly one cycle.
- lb at 0x103 with rdata=0x80FF_FF7F -> readdate1=0xFFFFFF80; lbu -> 0x00000080; lh at 0x102 -> 0xFFFF80FF.
- sb at 0x101 with wd=0x12345678 -> dmem_we=1, be=0010, wdata=0x78787878, Regwrite3=0.
- lw at 0x102 (misaligned) -> no dmem_req, stall=0, mem_err=1, Regwrite3=0.
- No ack, TIMEOUT=4 -> stall for 5 cycles, mem_err=1, readdate1=0; a late ack is ignored.
- Reset asserted in BUSY -> next cycle dmem_req=0, stall=0, mem_err=0; a following ALU op passes with no stall.
